keypad_scanner: RTL and testbench

//  Scans a 4x4 matrix keypad and produces the one-hot {row,col} key code that feeds key_to_digit_converter_2.

---
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low matrix keypad, debounces press and release, reports a one-hot {row,col} key code.
// Optional build macro KEYPAD_AUTOREPEAT_EN re-pulses key_valid every REPEAT_CYCLES while a key stays held.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int REPEAT_CYCLES   = 24000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_q, row_d;
  logic [7:0]    key_q, key_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic [3:0]    sync1_q, sync2_q;

  logic [3:0]    row_act;
  logic [3:0]    col_oh;
  logic          row_onehot;
  logic          row_hit;
  logic [DW-1:0] cnt_inc;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rpt_q, rpt_d;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_CYCLES;
`endif

  assign row_act    = ~sync2_q;
  assign col_oh     = 4'b0001 << col_q;
  assign row_onehot = (row_act != 4'b0000) && ((row_act & (row_act - 4'b0001)) == 4'b0000);
  assign row_hit    = |(row_act & row_q);
  // Saturating increment: a stuck counter must never wrap into a false accept.
  assign cnt_inc    = (cnt_q == {DW{1'b1}}) ? cnt_q : cnt_q + DW'(1);

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    scan_d  = scan_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d   = '0;
`endif
    case (state_q)
      ST_SCAN: begin
        if (scan_q == SCAN_LAST) begin
          scan_d = '0;
          if (row_onehot) begin
            row_d   = row_act;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end
      ST_DEBOUNCE: begin
        if (row_act != row_q) begin
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end else if (cnt_q >= DEB_LAST) begin
          // Row order is reversed so the top row lands in key[7].
          key_d   = {row_q[0], row_q[1], row_q[2], row_q[3], col_oh};
          valid_d = 1'b1;
          held_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HELD: begin
        if (!row_hit) begin
          cnt_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (rpt_q == RPT_LAST) begin
          valid_d = 1'b1;
        end else begin
          rpt_d = rpt_q + RW'(1);
        end
`endif
      end
      ST_RELEASE: begin
        if (row_hit) begin
          cnt_d = '0;
        end else if (cnt_q >= DEB_LAST) begin
          held_d  = 1'b0;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
          state_d = ST_SCAN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_SCAN;
      col_q   <= '0;
      scan_q  <= '0;
      cnt_q   <= '0;
      row_q   <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      sync1_q <= '1;
      sync2_q <= '1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      sync1_q <= row_n;
      sync2_q <= sync1_q;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  assign col_n     = ~col_oh;
  assign key       = key_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, directed scenarios, then randomized taps and holds
// checked against key codes and pulse counts derived from the keypad's rules.
module tb_keypad_scanner;
  localparam int SCAN = 4;
  localparam int DEB  = 8;
  localparam int RPT  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [7:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   pulses = 0;
  int   cyc = 0;
  int   last_pulse = -1;
  bit   mon_en = 1'b0;
  logic prev_vld = 1'b0;

  logic [3:0] exp_col;
  logic [7:0] model_key;
  logic [7:0] exp_key;
  int         p0;

  keypad_scanner #(
    .SCAN_CYCLES(SCAN),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_CYCLES(RPT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .row_n(row_n),
    .col_n(col_n),
    .key(key),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      chk("col_onehot", 32'($countones(~col_n)), 32'd1);
`ifdef KEYPAD_AUTOREPEAT_EN
      if (!key_held) last_pulse = -1;
`endif
      if (key_valid) begin
        pulses++;
        chk("vld_gap", 32'(prev_vld), 32'd0);
`ifdef KEYPAD_AUTOREPEAT_EN
        if (last_pulse >= 0) chk("rpt_gap", 32'(cyc - last_pulse), 32'(RPT));
        last_pulse = cyc;
`endif
      end
      prev_vld = key_valid;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    reset   = 1'b1;
    pressed = '0;

    // Reset values
    for (int i = 0; i < 3; i++) begin
      step();
      mon_en = 1'b1;
      chk("rst_col", 32'(col_n), 32'h0000_000E);
      chk("rst_key", 32'(key), 32'h0);
      chk("rst_vld", 32'(key_valid), 32'h0);
      chk("rst_held", 32'(key_held), 32'h0);
    end
    reset = 1'b0;

    // Idle scan: column index advances every SCAN cycles, wrapping 3 -> 0
    for (int k = 1; k <= 32; k++) begin
      step();
      exp_col = ~(4'b0001 << ((k / SCAN) % 4));
      chk("idle_col", 32'(col_n), 32'(exp_col));
    end
    chk("idle_pulses", pulses, 0);

    // "5": row1, col1
    p0 = pulses;
    pressed = 16'h0001 << (1*4 + 1);
    repeat (40) step();
    chk("k5_pulses", pulses - p0, 1);
    chk("k5_key", 32'(key), 32'h42);
    chk("k5_held", 32'(key_held), 32'h1);
    pressed = '0;
    repeat (7) step();
    chk("k5_held_during_rel", 32'(key_held), 32'h1);
    repeat (8) step();
    chk("k5_held_after_rel", 32'(key_held), 32'h0);
    chk("k5_key_kept", 32'(key), 32'h42);

    // "A" bouncing 3 on / 1 off never settles long enough
    p0 = pulses;
    for (int i = 0; i < 12; i++) begin
      pressed = 16'h0001 << (3*4 + 0);
      repeat (3) step();
      pressed = '0;
      step();
    end
    chk("bounce_pulses", pulses - p0, 0);
    chk("bounce_key", 32'(key), 32'h42);
    pressed = 16'h0001 << (3*4 + 0);
    repeat (40) step();
    chk("kA_pulses", pulses - p0, 1);
    chk("kA_key", 32'(key), 32'h11);
    pressed = '0;
    repeat (20) step();

    // "1" + "4" share column 0: two rows active, rejected
    p0 = pulses;
    pressed = 16'h0001 | 16'h0010;
    repeat (40) step();
    chk("multi_pulses", pulses - p0, 0);
    chk("multi_key", 32'(key), 32'h11);
    pressed = '0;
    repeat (4) step();
    pressed = 16'h0001 << (3*4 + 3);
    repeat (40) step();
    chk("kF_pulses", pulses - p0, 1);
    chk("kF_key", 32'(key), 32'h18);
    pressed = '0;
    repeat (20) step();

    // "C": row0, col3, long hold
    p0 = pulses;
    pressed = 16'h0001 << (0*4 + 3);
    repeat (60) step();
    chk("kC_key", 32'(key), 32'h88);
`ifdef KEYPAD_AUTOREPEAT_EN
    chk("kC_repeats", 32'(pulses - p0 >= 2), 32'h1);
`else
    chk("kC_pulses", pulses - p0, 1);
`endif
    pressed = '0;
    repeat (20) step();

    // Reset while "1" is being debounced in column 0
    p0 = pulses;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    pressed = 16'h0001;
    repeat (6) step();
    reset = 1'b1;
    step();
    chk("midrst_col", 32'(col_n), 32'h0000_000E);
    chk("midrst_key", 32'(key), 32'h0);
    chk("midrst_vld", 32'(key_valid), 32'h0);
    chk("midrst_held", 32'(key_held), 32'h0);
    step();
    step();
    reset = 1'b0;
    pressed = '0;
    repeat (12) step();
    chk("midrst_pulses", pulses - p0, 0);
    model_key = 8'h00;

    // Randomized taps, holds, and holds with a second key in another column
    for (int e = 0; e < 24; e++) begin
      int r;
      int c;
      int c2;
      int r2;
      int mode;
      int w;
      r    = int'($urandom_range(0, 3));
      c    = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 2));
      exp_key = (8'h80 >> r) | (8'h01 << c);
      p0 = pulses;
      repeat ($urandom_range(0, 7)) step();
      if (mode == 0) begin
        pressed = 16'h0001 << (r*4 + c);
        repeat ($urandom_range(1, DEB - 1)) step();
        pressed = '0;
        repeat (20) step();
        chk("tap_pulses", pulses - p0, 0);
        chk("tap_key", 32'(key), 32'(model_key));
      end else begin
        pressed = 16'h0001 << (r*4 + c);
        w = 0;
        while (pulses == p0 && w < 60) begin
          step();
          w++;
        end
        chk("hold_accepted", 32'(pulses != p0), 32'h1);
        chk("hold_key", 32'(key), 32'(exp_key));
        chk("hold_held", 32'(key_held), 32'h1);
        if (mode == 2) begin
          c2 = (c + int'($urandom_range(1, 3))) % 4;
          r2 = int'($urandom_range(0, 3));
          pressed = pressed | (16'h0001 << (r2*4 + c2));
          repeat (20) step();
          chk("other_key_ignored", 32'(key), 32'(exp_key));
        end
        pressed = '0;
        repeat (20) step();
        chk("hold_released", 32'(key_held), 32'h0);
        chk("hold_key_kept", 32'(key), 32'(exp_key));
`ifndef KEYPAD_AUTOREPEAT_EN
        chk("hold_pulses", pulses - p0, 1);
`endif
        model_key = exp_key;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
